// File: rtl/syndet_pkg.sv
// Shared types and constants for the syndet acquisition/tracking controller.
package syndet_pkg;

  localparam int unsigned SYN_CW = 14;
  localparam int unsigned SYN_LW = 6;

  localparam int unsigned SYN_FLUSH_CYC = 320;
  localparam int unsigned SYN_HIT_N     = 4;
  localparam int unsigned SYN_MISS_N    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SEARCH = 2'd2,
    LOCKED = 2'd3
  } syndet_ctrl_state_t;

endpackage

// File: rtl/syn_hyst_cnt.sv
// Saturating consecutive-event counter; done holds while the run length has reached N.
module syn_hyst_cnt #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic done
);

  localparam int unsigned W = $clog2(N + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(N))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == W'(N));

endmodule

// File: rtl/syndet_ctrl.sv
// Acquisition/tracking controller for the syndet correlator: flush, search, lock with hysteresis.
// Optional peak tracker is built when SYNDET_CTRL_PEAK_EN is defined.
module syndet_ctrl
  import syndet_pkg::*;
#(
  parameter int unsigned CW        = SYN_CW,
  parameter int unsigned LW        = SYN_LW,
  parameter int unsigned FLUSH_CYC = SYN_FLUSH_CYC,
  parameter int unsigned HIT_N     = SYN_HIT_N,
  parameter int unsigned MISS_N    = SYN_MISS_N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          restart,
  input  logic [LW-1:0] length_cfg,
  input  logic [CW-1:0] thr_acq,
  input  logic [CW-1:0] thr_loss,
  input  logic [CW-1:0] corr,
  input  logic          corr_v,
  output logic          det_rst,
  output logic [LW-1:0] det_len,
  output logic          locked,
  output logic          acq_pulse,
  output logic          lost_pulse,
  output logic [1:0]    state
`ifdef SYNDET_CTRL_PEAK_EN
  ,
  output logic [CW-1:0] peak,
  output logic [LW-1:0] peak_idx
`endif
);

  localparam int unsigned FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  syndet_ctrl_state_t st_q, st_n;
  logic [FW-1:0]      fcnt_q, fcnt_n;
  logic               load_len;
  logic               acq_n, lost_n;
  logic               hit_inc, hit_clr, hit_done;
  logic               miss_inc, miss_clr, miss_done;

  // Counters only run in their own state and reset whenever it is left.
  assign hit_inc  = (st_q == SEARCH) && corr_v && (corr >= thr_acq);
  assign hit_clr  = (st_q != SEARCH) || (corr_v && (corr < thr_acq));
  assign miss_inc = (st_q == LOCKED) && corr_v && (corr < thr_loss);
  assign miss_clr = (st_q != LOCKED) || (corr_v && (corr >= thr_loss));

  syn_hyst_cnt #(.N(HIT_N)) u_hit_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (hit_inc),
    .clr  (hit_clr),
    .done (hit_done)
  );

  syn_hyst_cnt #(.N(MISS_N)) u_miss_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (miss_inc),
    .clr  (miss_clr),
    .done (miss_done)
  );

  always_comb begin
    st_n     = st_q;
    fcnt_n   = fcnt_q;
    load_len = 1'b0;
    acq_n    = 1'b0;
    lost_n   = 1'b0;
    if (!enable) begin
      st_n   = IDLE;
      fcnt_n = '0;
    end else if ((st_q == IDLE) || restart) begin
      st_n     = FLUSH;
      fcnt_n   = '0;
      load_len = 1'b1;
    end else begin
      unique case (st_q)
        FLUSH: begin
          if (fcnt_q == FW'(FLUSH_CYC - 1)) begin
            st_n = SEARCH;
          end else begin
            fcnt_n = fcnt_q + 1'b1;
          end
        end
        SEARCH: begin
          if (hit_done) begin
            st_n  = LOCKED;
            acq_n = 1'b1;
          end
        end
        LOCKED: begin
          if (miss_done) begin
            st_n   = SEARCH;
            lost_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next-state so they align with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      fcnt_q     <= '0;
      det_rst    <= 1'b1;
      det_len    <= '1;
      locked     <= 1'b0;
      acq_pulse  <= 1'b0;
      lost_pulse <= 1'b0;
    end else begin
      st_q       <= st_n;
      fcnt_q     <= fcnt_n;
      det_rst    <= (st_n == IDLE) || (st_n == FLUSH);
      locked     <= (st_n == LOCKED);
      acq_pulse  <= acq_n;
      lost_pulse <= lost_n;
      if (load_len) begin
        det_len <= length_cfg;
      end
    end
  end

  assign state = st_q;

`ifdef SYNDET_CTRL_PEAK_EN
  logic [LW-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst || load_len) begin
      peak     <= '0;
      peak_idx <= '0;
      idx_q    <= '0;
    end else if (((st_q == SEARCH) || (st_q == LOCKED)) && corr_v) begin
      if (corr > peak) begin
        peak     <= corr;
        peak_idx <= idx_q;
      end
      idx_q <= (idx_q == det_len) ? '0 : idx_q + 1'b1;
    end
  end
`endif

endmodule
